// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_mp_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;
  localparam int RF_AW     = $clog2(RF_NREGS);

  typedef logic [RF_DATA_W-1:0] word_t;
  typedef logic [RF_AW-1:0]     regid_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits and registered pending count
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREGS-1:0]  pend,
  output logic [AW:0]       pend_cnt
);

  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;

  // Clears are applied before the set so a same-cycle issue (newer producer) wins.
  always_comb begin
    pend_nxt = pend;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) pend_nxt[wr_addr[k*AW +: AW]] = 1'b0;
    end
    if (iss_valid) pend_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;

    cnt_nxt = '0;
    for (int a = 0; a < NREGS; a++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[a]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write->read bypass and pending-write scoreboard
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  output logic [AW:0]           pend_cnt
);

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  pend;

  // Ascending port order: the highest-numbered port's assignment lands last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NREGS; a++) mem[a] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*AW +: AW] == '0))
          mem[wr_addr[k*AW +: AW]] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .pend      (pend),
    .pend_cnt  (pend_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] data;
    logic              hit;
    logic              is_zero;

    assign ra      = rd_addr[i*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);

    // Forwarding is suppressed while reset is held so outputs read as zero.
    always_comb begin
      data = mem[ra];
      hit  = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (BYPASS != 0 && rst && wr_en[k] && wr_addr[k*AW +: AW] == ra) begin
          data = wr_data[k*DATA_W +: DATA_W];
          hit  = 1'b1;
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = is_zero ? '0 : data;
    assign rd_busy[i]                  = is_zero ? 1'b0 : (pend[ra] & ~hit);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and randomized bench for regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int AW     = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  iss_valid;
  logic [AW-1:0]         iss_addr;
  logic [AW:0]           pend_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [DATA_W-1:0] m_reg  [NREGS];
  bit                m_pend [NREGS];

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rdd(input int i);
    return rd_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_idle();
    wr_en     = '0;
    iss_valid = 1'b0;
  endtask

  task automatic do_wr(input int k, input int a, input logic [DATA_W-1:0] d);
    wr_en[k]                    = 1'b1;
    wr_addr[k*AW +: AW]         = AW'(a);
    wr_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic do_iss(input int a);
    iss_valid = 1'b1;
    iss_addr  = AW'(a);
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int a = 0; a < NREGS; a++) c += int'(m_pend[a]);
    return c;
  endfunction

  // Reference read: reg 0 reads zero, else the last enabled write port targeting the
  // address supplies the value; a forwarded write also clears the hazard.
  task automatic check_reads();
    for (int i = 0; i < NRD; i++) begin
      int a = int'(rd_addr[i*AW +: AW]);
      logic [DATA_W-1:0] ed = m_reg[a];
      bit eb = m_pend[a];
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) begin
          ed = wr_data[k*DATA_W +: DATA_W];
          eb = 1'b0;
        end
      end
      if (a == 0) begin
        ed = '0;
        eb = 1'b0;
      end
      chk($sformatf("rd_data[%0d] a=%0d", i, a), 64'(rdd(i)), 64'(ed));
      chk($sformatf("rd_busy[%0d] a=%0d", i, a), 64'(rd_busy[i]), 64'(eb));
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NWR; k++) begin
      int a = int'(wr_addr[k*AW +: AW]);
      if (wr_en[k] && a != 0) begin
        m_reg[a]  = wr_data[k*DATA_W +: DATA_W];
        m_pend[a] = 1'b0;
      end
    end
    if (iss_valid && iss_addr != '0) m_pend[int'(iss_addr)] = 1'b1;
  endtask

  task automatic model_clear();
    for (int a = 0; a < NREGS; a++) begin
      m_reg[a]  = '0;
      m_pend[a] = 1'b0;
    end
  endtask

  // Inputs are set just after a rising edge; this checks them, clocks, and checks the count.
  task automatic step();
    #2;
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
    chk("pend_cnt", 64'(pend_cnt), 64'(model_cnt()));
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    set_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pend_cnt", 64'(pend_cnt), 64'd0);
    chk("reset rd_data", 64'(rd_data), 64'd0);
    chk("reset rd_busy", 64'(rd_busy), 64'd0);
    rst = 1'b1;

    // Bypass then storage read of r5
    do_wr(0, 5, 32'hDEADBEEF); do_rd(0, 5);
    #1;
    chk("bypass r5", 64'(rdd(0)), 64'hDEADBEEF);
    step();
    set_idle();
    #1;
    chk("stored r5", 64'(rdd(0)), 64'hDEADBEEF);

    // Two ports, same address: port 1 wins
    do_wr(0, 7, 32'h11); do_wr(1, 7, 32'h22);
    step();
    set_idle(); do_rd(0, 7);
    #1;
    chk("r7 port1 wins", 64'(rdd(0)), 64'h22);

    // Writes and issues to r0 are ignored
    do_wr(0, 0, 32'h1234); do_iss(0); do_rd(0, 0);
    step();
    set_idle();
    #1;
    chk("r0 data", 64'(rdd(0)), 64'd0);
    chk("r0 busy", 64'(rd_busy[0]), 64'd0);
    chk("r0 pend_cnt", 64'(pend_cnt), 64'd0);

    // Issue r3, then writeback resolves the hazard in the same cycle
    do_iss(3);
    step();
    set_idle(); do_rd(0, 3);
    #1;
    chk("r3 busy", 64'(rd_busy[0]), 64'd1);
    chk("r3 pend_cnt", 64'(pend_cnt), 64'd1);
    do_wr(0, 3, 32'h55);
    #1;
    chk("r3 wb busy", 64'(rd_busy[0]), 64'd0);
    chk("r3 wb data", 64'(rdd(0)), 64'h55);
    step();
    set_idle();
    chk("r3 cleared cnt", 64'(pend_cnt), 64'd0);

    // Issue and writeback of r9 together: data stored, still pending
    do_iss(9); do_wr(0, 9, 32'h77);
    step();
    set_idle(); do_rd(1, 9);
    #1;
    chk("r9 data", 64'(rdd(1)), 64'h77);
    chk("r9 busy", 64'(rd_busy[1]), 64'd1);
    chk("r9 pend_cnt", 64'(pend_cnt), 64'd1);

    // Randomized traffic, addresses biased low to force collisions
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NWR; k++) begin
        wr_en[k] = 1'($urandom_range(0, 1));
        do_wr(k, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
              $urandom);
        wr_en[k] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NRD; i++) do_rd(i, int'($urandom_range(0, 7)));
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = AW'($urandom_range(0, 9));
      step();
    end

    // Asynchronous reset mid-run with live write traffic
    do_wr(0, 4, 32'hCAFE0004); do_wr(1, 6, 32'hCAFE0006); do_rd(0, 4); do_rd(1, 6);
    #3;
    rst = 1'b0;
    #1;
    chk("mid reset rd_data", 64'(rd_data), 64'd0);
    chk("mid reset rd_busy", 64'(rd_busy), 64'd0);
    chk("mid reset pend_cnt", 64'(pend_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("held reset rd_data", 64'(rd_data), 64'd0);
    model_clear();
    set_idle();
    rst = 1'b1;
    #1;
    chk("post reset r4", 64'(rdd(0)), 64'd0);
    do_iss(12);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
